// File: rtl/microcode_seq.sv
// ============================================================================
// Module      : microcode_seq
// Description : Issues one micro-op index per cycle to the microcode ROM for
//               each dispatched run; stalls on mem_busy, aborts on flush and
//               drops runs that would index past the populated table.
//               Optional stall counter enabled by MICROSEQ_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_seq #(
    parameter int UOP_AW    = 6,
    parameter int LEN_W     = 3,
    parameter int UOP_DEPTH = 49
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic [UOP_AW-1:0] dispatch_uaddr,
    input  logic [LEN_W-1:0]  dispatch_len,
    input  logic              mem_busy,
    input  logic              flush,
    output logic [UOP_AW-1:0] uop_index,
    output logic              uop_valid,
    output logic              uop_last,
    output logic              busy,
    output logic              range_err
`ifdef MICROSEQ_STALL_CNT_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0]  c_len_max = CNT_W'(2 ** LEN_W);
    localparam logic [UOP_AW:0]   c_depth   = (UOP_AW + 1)'(UOP_DEPTH);

    state_t            r_state, w_state_nxt;
    logic [UOP_AW-1:0] r_uop_index, w_uop_index_nxt;
    logic [CNT_W-1:0]  r_remaining, w_remaining_nxt;
    logic              r_uop_last, w_uop_last_nxt;
    logic              r_range_err, w_range_err_nxt;

    logic [CNT_W-1:0]  w_len_eff;
    logic [UOP_AW:0]   w_end;
    logic              w_in_range;
    logic              w_run;
    logic              w_ready;
    logic              w_accept;

    // One extra bit on the end address so uaddr + len can't alias back into range
    assign w_len_eff  = (dispatch_len == '0) ? c_len_max : {1'b0, dispatch_len};
    assign w_end      = {1'b0, dispatch_uaddr} + (UOP_AW + 1)'(w_len_eff);
    assign w_in_range = (w_end <= c_depth);

    assign w_run    = (r_state == S_RUN);
    assign w_ready  = rst_n & ~flush & (~w_run | (r_uop_last & ~mem_busy));
    assign w_accept = dispatch_valid & w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_uop_index <= '0;
            r_remaining <= '0;
            r_uop_last  <= 1'b0;
            r_range_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_uop_index <= w_uop_index_nxt;
            r_remaining <= w_remaining_nxt;
            r_uop_last  <= w_uop_last_nxt;
            r_range_err <= w_range_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_uop_index_nxt = r_uop_index;
        w_remaining_nxt = r_remaining;
        w_uop_last_nxt  = r_uop_last;
        w_range_err_nxt = r_range_err;

        if (flush) begin
            w_state_nxt     = S_IDLE;
            w_remaining_nxt = '0;
            w_uop_last_nxt  = 1'b0;
        end else if (w_accept) begin
            // Covers both an idle accept and the no-bubble follow-on after a last step
            if (w_in_range) begin
                w_state_nxt     = S_RUN;
                w_uop_index_nxt = dispatch_uaddr;
                w_remaining_nxt = w_len_eff;
                w_uop_last_nxt  = (w_len_eff == CNT_W'(1));
            end else begin
                w_state_nxt     = S_IDLE;
                w_remaining_nxt = '0;
                w_uop_last_nxt  = 1'b0;
                w_range_err_nxt = 1'b1;
            end
        end else if (w_run && !mem_busy) begin
            if (!r_uop_last) begin
                w_uop_index_nxt = r_uop_index + UOP_AW'(1);
                w_remaining_nxt = r_remaining - CNT_W'(1);
                w_uop_last_nxt  = (r_remaining == CNT_W'(2));
            end else begin
                w_state_nxt     = S_IDLE;
                w_remaining_nxt = '0;
                w_uop_last_nxt  = 1'b0;
            end
        end
    end

    assign dispatch_ready = w_ready;
    assign uop_index      = r_uop_index;
    assign uop_valid      = rst_n & w_run & ~mem_busy;
    assign uop_last       = r_uop_last;
    assign busy           = w_run;
    assign range_err      = r_range_err;

`ifdef MICROSEQ_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_run && mem_busy && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire
